// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: board clock constants and counter sizing shared by fabric-only blocks
package button_debounce_pkg;

    localparam int CLK_HZ        = 125_000_000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int LONG_1S       = CLK_HZ;

    // Width of a counter that must be able to hold the value max_val
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// button_debounce_if: raw button pins in, debounced level and event pulses out
interface button_debounce_if #(
    parameter int NUM_BTN = 4
);

    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );

endinterface

// File: rtl/button_debounce_channel.sv
// button_debounce_channel: one button bit -- synchroniser, debounce counter, long-press timer
module button_debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hold_cnt;
    logic          w_differ;
    logic          w_accept;

    assign w_differ = r_sync2 != r_level;
    assign w_accept = w_differ && (r_db_cnt == DB_LAST);

    // Two-flop synchroniser; only r_sync2 is trusted downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the run
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_db_cnt  <= (w_differ && !w_accept) ? r_db_cnt + 1'b1 : '0;
            r_level   <= w_accept ? r_sync2 : r_level;
            r_press   <= w_accept && r_sync2;
            r_release <= w_accept && !r_sync2;
        end
    end

    // Count accepted-high cycles, saturating so the long pulse fires once per hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            r_hold_cnt <= !r_level ? '0 : (r_hold_cnt == HOLD_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
            r_long     <= r_level && (r_hold_cnt == HOLD_MAX - 1'b1);
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: NUM_BTN independent debounced button channels with press/release/long pulses
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S
) (
    input logic                clk,
    input logic                rst,
    button_debounce_if.slave   bus
);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_release;
    logic [NUM_BTN-1:0] w_long;

    genvar i;
    for (i = 0; i < NUM_BTN; i++) begin : g_ch
        button_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_btn     (bus.btn_in[i]),
            .o_level   (w_level[i]),
            .o_press   (w_press[i]),
            .o_release (w_release[i]),
            .o_long    (w_long[i])
        );
    end

    assign bus.btn_level   = w_level;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_long    = w_long;

endmodule
